// File: rtl/scalar_arith_pkg.sv
// Shared constants and state encoding for the scalar arithmetic arbiter.
package scalar_arith_pkg;

  localparam int SCALAR_W = 256;
  localparam int RESULT_W = 253;

  // Group order L = 2^252 + 27742317777372353535851937790883648493.
  localparam logic [RESULT_W-1:0] L_ORDER =
    253'h1_0000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

  // ST_ABORT is only reachable when SCALAR_ARB_TIMEOUT_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/scalar_arith_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1 (mod NREQ). Produces a one-hot winner and its index.
module rr_pick
  import scalar_arith_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_any
);

  // Scan the requesters in rotating order, keep the first one found.
  always_comb begin : pick
    logic [IW-1:0] cand;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!win_any && req[cand]) begin
        win_any       = 1'b1;
        win_oh[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/scalar_arith_arbiter.sv
// Round-robin arbiter sharing one scalar arithmetic unit (s = k*s + r mod L)
// between NREQ requesters. Latches the winner's operands, runs the unit's
// start/done handshake and returns the result with a one-cycle valid pulse.
// Optional feature: define SCALAR_ARB_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT_CYCLES and report expiry on err through a one-cycle ABORT state.
module scalar_arith_arbiter
  import scalar_arith_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SCALAR_W-1:0] k_in,
  input  logic [NREQ*SCALAR_W-1:0] s_in,
  input  logic [NREQ*SCALAR_W-1:0] r_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          res_valid,
  output logic [RESULT_W-1:0]      res_data,
  output logic [NREQ-1:0]          err,
  output logic                     busy,
  output logic                     au_start,
  output logic [SCALAR_W-1:0]      au_k,
  output logic [SCALAR_W-1:0]      au_s,
  output logic [SCALAR_W-1:0]      au_r,
  input  logic                     au_done,
  input  logic                     au_busy,
  input  logic [RESULT_W-1:0]      au_s_out
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("scalar_arith_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("scalar_arith_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign busy = (state != ST_IDLE);

`ifdef SCALAR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
`else
  assign err = '0;
`endif

  // Control FSM; operands move only on a grant so the unit can read them late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= IW'(NREQ - 1);
      owner     <= '0;
      gnt       <= '0;
      res_valid <= '0;
      res_data  <= '0;
      au_start  <= 1'b0;
      au_k      <= '0;
      au_s      <= '0;
      au_r      <= '0;
`ifdef SCALAR_ARB_TIMEOUT_EN
      err       <= '0;
      tcnt      <= '0;
`endif
    end else begin
      gnt       <= '0;
      res_valid <= '0;
      au_start  <= 1'b0;
`ifdef SCALAR_ARB_TIMEOUT_EN
      err       <= '0;
`endif
      case (state)
        ST_IDLE: begin
          // au_done arriving here belongs to nobody and is dropped.
          if (win_any) begin
            au_k  <= k_in[SCALAR_W*win_idx +: SCALAR_W];
            au_s  <= s_in[SCALAR_W*win_idx +: SCALAR_W];
            au_r  <= r_in[SCALAR_W*win_idx +: SCALAR_W];
            owner <= win_idx;
            gnt   <= win_oh;
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!au_busy) begin
            au_start <= 1'b1;
            state    <= ST_WAIT;
`ifdef SCALAR_ARB_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (au_done) begin
            res_data         <= au_s_out;
            res_valid[owner] <= 1'b1;
            ptr              <= owner;
            state            <= ST_IDLE;
          end
`ifdef SCALAR_ARB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err[owner] <= 1'b1;
            state      <= ST_ABORT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
`ifdef SCALAR_ARB_TIMEOUT_EN
        ST_ABORT: begin
          ptr   <= owner;
          state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_arith_arbiter.sv
// Bench for scalar_arith_arbiter: a behavioural arithmetic-unit stub, a
// round-robin/result scoreboard monitor and directed plus random stimulus.
module tb_scalar_arith_arbiter;

  localparam int NREQ = 2;
  localparam int TOUT = 16;
  localparam logic [252:0] L_REF =
    253'h1_0000000_00000000_00000000_00000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*256-1:0]  k_in, s_in, r_in;
  logic [NREQ-1:0]      gnt, res_valid, err;
  logic [252:0]         res_data;
  logic                 busy, au_start, au_done, au_busy;
  logic [255:0]         au_k, au_s, au_r;
  logic [252:0]         au_s_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           idx;
    logic [252:0] data;
  } exp_t;
  exp_t sb[$];

  bit stub_hang = 0;
  int stray_req = 0;
  int stray_ack = 0;

  scalar_arith_arbiter #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .k_in      (k_in),
    .s_in      (s_in),
    .r_in      (r_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .busy      (busy),
    .au_start  (au_start),
    .au_k      (au_k),
    .au_s      (au_s),
    .au_r      (au_r),
    .au_done   (au_done),
    .au_busy   (au_busy),
    .au_s_out  (au_s_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: (k*s + r) mod L with wide plain arithmetic.
  function automatic logic [252:0] ref_res(input logic [255:0] k, input logic [255:0] s,
                                           input logic [255:0] r);
    logic [527:0] acc;
    acc = {272'd0, k} * {272'd0, s} + {272'd0, r};
    return 253'(acc % {275'd0, L_REF});
  endfunction

  // Round-robin rule: first requester found searching upward from p+1.
  function automatic int rr_winner(input logic [NREQ-1:0] rq, input int p);
    for (int i = 1; i <= NREQ; i++)
      if (rq[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // Arithmetic unit stub: latches k,s on start, reads r late at completion.
  initial begin
    bit           active, moved;
    int           cnt;
    logic [255:0] lk, ls, lr;
    active = 0; moved = 0; cnt = 0; lk = '0; ls = '0; lr = '0;
    au_done = 1'b0;
    au_s_out = '0;
    forever begin
      @(posedge clk); #1;
      au_done = 1'b0;
      if (rst) begin
        active = 0;
        continue;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        au_done   = 1'b1;
        au_s_out  = 253'h1234;
      end else if (active) begin
        if (au_k !== lk || au_s !== ls || au_r !== lr) moved = 1;
        if (cnt == 0) begin
          check("au_ops_stable", 256'(moved), 256'(0));
          check("au_r_late", au_r, lr);
          au_s_out = ref_res(lk, ls, au_r);
          au_done  = 1'b1;
          active   = 0;
        end else begin
          cnt--;
        end
      end
      if (au_start) begin
        lk = au_k; ls = au_s; lr = au_r;
        moved  = 0;
        cnt    = $urandom_range(0, 5);
        active = !stub_hang;
      end
    end
  end

  // Monitor: predicts grants, checks launch timing and scores results/errors.
  initial begin
    int           mptr, pend_w;
    bit           pend_g, launch_p, prev_busy, wait_act, prev_done;
    logic [252:0] pend_d;
    exp_t         e;
    mptr = NREQ - 1; pend_w = 0; pend_g = 0; launch_p = 0;
    prev_busy = 0; wait_act = 0; prev_done = 0; pend_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mptr = NREQ - 1; pend_g = 0; launch_p = 0;
        wait_act = 0; prev_done = 0; prev_busy = 0;
        sb.delete();
        continue;
      end
      if (prev_done) begin
        if (sb.size() == 0) begin
          check("res_no_owner", 256'(res_valid), 256'(0));
        end else begin
          e = sb.pop_front();
          check("res_owner", 256'(res_valid), 256'(1 << e.idx));
          check("res_data", 256'(res_data), 256'(e.data));
          mptr = e.idx;
        end
        wait_act = 0;
      end else if (|res_valid) begin
        check("res_spurious", 256'(res_valid), 256'(0));
      end
      if (|err) begin
        if (sb.size() == 0) begin
          check("err_spurious", 256'(err), 256'(0));
        end else begin
          e = sb.pop_front();
          check("err_owner", 256'(err), 256'(1 << e.idx));
          mptr = e.idx;
        end
        wait_act = 0;
      end
      if (launch_p) begin
        if (!prev_busy) begin
          check("au_start_due", 256'(au_start), 256'(1));
          launch_p = 0;
          wait_act = 1;
        end else begin
          check("au_start_held", 256'(au_start), 256'(0));
        end
      end else if (au_start) begin
        check("au_start_spurious", 256'(au_start), 256'(0));
      end
      if (pend_g) begin
        check("gnt_winner", 256'(gnt), 256'(1 << pend_w));
        sb.push_back('{pend_w, pend_d});
        launch_p = 1;
        pend_g   = 0;
      end else if (|gnt) begin
        check("gnt_spurious", 256'(gnt), 256'(0));
      end
      prev_done = au_done && wait_act;
      if (!busy && |req) begin
        pend_w = rr_winner(req, mptr);
        pend_g = 1;
        pend_d = ref_res(k_in[256*pend_w +: 256], s_in[256*pend_w +: 256],
                         r_in[256*pend_w +: 256]);
      end
      prev_busy = au_busy;
    end
  end

  task automatic set_ops(input int i, input logic [255:0] k, input logic [255:0] s,
                         input logic [255:0] r);
    k_in[256*i +: 256] = k;
    s_in[256*i +: 256] = s;
    r_in[256*i +: 256] = r;
  endtask

  task automatic wait_gnt(input int i);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!gnt[i] && c < 200);
    if (!gnt[i]) check("gnt_timeout", 256'(gnt[i]), 256'(1));
  endtask

  task automatic wait_res(input int i, output logic [252:0] res);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!res_valid[i] && c < 200);
    if (!res_valid[i]) check("res_timeout", 256'(res_valid[i]), 256'(1));
    res = res_data;
  endtask

  task automatic wait_start();
    int c;
    c = 0;
    while (!au_start && c < 50) begin
      @(posedge clk); #1; c++;
    end
    if (!au_start) check("start_timeout", 256'(au_start), 256'(1));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    if (busy) check("idle_timeout", 256'(busy), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int i, input logic [255:0] k, input logic [255:0] s,
                        input logic [255:0] r, output logic [252:0] res);
    set_ops(i, k, s, r);
    req[i] = 1'b1;
    wait_gnt(i);
    req[i] = 1'b0;
    wait_res(i, res);
    wait_idle();
  endtask

  initial begin
    logic [252:0] res;
    logic [3:0]   mask;
    int           c, saw;
    int           order[$];

    req = '0; k_in = '0; s_in = '0; r_in = '0; au_busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 256'(gnt), 256'(0));
    check("rst_res_valid", 256'(res_valid), 256'(0));
    check("rst_res_data", 256'(res_data), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_au_start", 256'(au_start), 256'(0));
    check("rst_au_k", au_k, 256'(0));
    check("rst_au_r", au_r, 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single operation with cycle-exact handshake timing.
    set_ops(0, 256'd2, 256'd3, 256'd5);
    req[0] = 1'b1;
    @(posedge clk); #1;
    check("single_gnt_t1", 256'(gnt), 256'(2'b01));
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("single_start_t2", 256'(au_start), 256'(1));
    wait_res(0, res);
    check("single_res", 256'(res), 256'(11));
    @(posedge clk); #1;
    check("res_valid_width", 256'(res_valid), 256'(0));
    wait_idle();

    // Boundary values around the group order.
    run_op(0, 256'd0, 256'd0, 256'(L_REF - 253'd1), res);
    check("bound_l_minus_1", 256'(res), 256'(L_REF - 253'd1));
    run_op(1, 256'd1, 256'd1, 256'(L_REF - 253'd1), res);
    check("bound_wrap_zero", 256'(res), 256'(0));

    // Busy unit: au_busy high for 5 cycles from the grant cycle.
    set_ops(1, rand256(), rand256(), rand256());
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    au_busy = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
      if (c == 5) au_busy = 1'b0;
    end while (!au_start && c < 30);
    check("busy_start_delay", 256'(c), 256'(6));
    wait_res(1, res);
    wait_idle();

    // Random traffic with random unit stalls.
    for (int it = 0; it < 14; it++) begin
      mask = 4'($urandom_range(1, 3));
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) set_ops(i, rand256(), rand256(), rand256());
      req = mask[NREQ-1:0];
      c = 0;
      while (req != '0 && c < 400) begin
        @(posedge clk); #1; c++;
        au_busy = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < NREQ; i++)
          if (gnt[i]) req[i] = 1'b0;
      end
      if (req != '0) check("rand_gnt_timeout", 256'(req), 256'(0));
      req = '0;
      au_busy = 1'b0;
      wait_idle();
    end

    // Contention from reset: both held, grants must alternate 0,1,0,1...
    rst = 1'b1;
    set_ops(0, rand256(), rand256(), rand256());
    set_ops(1, rand256(), rand256(), rand256());
    req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0;
    while (order.size() < 6 && c < 600) begin
      @(posedge clk); #1; c++;
      for (int i = 0; i < NREQ; i++)
        if (gnt[i]) begin
          order.push_back(i);
          set_ops(i, rand256(), rand256(), rand256());
        end
    end
    req = '0;
    check("contention_count", 256'(order.size()), 256'(6));
    for (int j = 0; j < order.size(); j++)
      check($sformatf("contention_order_%0d", j), 256'(order[j]), 256'(j % 2));
    wait_idle();

    // Reset in the middle of WAIT, then a stray done must be dropped.
    stub_hang = 1;
    set_ops(0, rand256(), rand256(), rand256());
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_gnt", 256'(gnt), 256'(0));
    check("midrst_res_data", 256'(res_data), 256'(0));
    check("midrst_au_k", au_k, 256'(0));
    check("midrst_au_s", au_s, 256'(0));
    check("midrst_au_r", au_r, 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_start", 256'(au_start), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    stub_hang = 0;
    stray_req++;
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (|res_valid) saw++;
    end
    check("stray_done_dropped", 256'(saw), 256'(0));
    run_op(1, 256'd7, 256'd6, 256'd1, res);
    check("post_reset_res", 256'(res), 256'(43));

`ifdef SCALAR_ARB_TIMEOUT_EN
    // Unit never completes: err pulses after TOUT WAIT cycles, no result.
    stub_hang = 1;
    set_ops(0, rand256(), rand256(), rand256());
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_start();
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!err[0] && c < 60);
    check("timeout_cycles", 256'(c), 256'(TOUT));
    check("timeout_err", 256'(err), 256'(2'b01));
    check("timeout_no_res", 256'(res_valid), 256'(0));
    @(posedge clk); #1;
    check("timeout_err_width", 256'(err), 256'(0));
    stub_hang = 0;
    wait_idle();
    run_op(1, 256'd4, 256'd5, 256'd6, res);
    check("after_timeout_res", 256'(res), 256'(26));
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
